// File: rtl/color_matrix_stream_if.sv
// rtl/color_matrix_stream_if.sv - pixel stream handshake bundle for color_matrix_stream
//
// Groups the input and output valid/ready pixel streams.
//   in_valid/in_ready/in_sof/in_eol/in_rgb      : upstream pixel beat
//   out_valid/out_ready/out_sof/out_eol/out_rgb : downstream pixel beat
//   {R,G,B} packing, R in the MSBs.
// slave  : view taken by the transform block
// master : view taken by the surrounding source/sink
interface color_matrix_stream_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic                  in_eol;
    logic [3*DATA_W-1:0]   in_rgb;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eol;
    logic [3*DATA_W-1:0]   out_rgb;

    modport slave (
        input  in_valid, in_sof, in_eol, in_rgb, out_ready,
        output in_ready, out_valid, out_sof, out_eol, out_rgb
    );

    modport master (
        output in_valid, in_sof, in_eol, in_rgb, out_ready,
        input  in_ready, out_valid, out_sof, out_eol, out_rgb
    );
endinterface

// File: rtl/color_matrix_stream.sv
// rtl/color_matrix_stream.sv - streaming 3x3 fixed-point colour matrix with saturation
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   sel                 : mode request (0 bypass, 1 sepia, 2 grayscale, 3 custom),
//                         sampled only on an accepted start-of-frame beat
//   px (slave)          : input/output pixel streams with sof/eol sideband
//   cfg_we/addr/data    : custom coefficient shadow bank write port (index 0..8, row-major)
//   frame_mode          : mode in force for the current frame
//
// Pipeline: S1 products, S2 row sums (+rounding), S3 round/saturate into the
// output register. One global enable stalls every stage together.
module color_matrix_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          sel,
    color_matrix_stream_if.slave px,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [COEF_W-1:0]   cfg_data,
    output logic [1:0]          frame_mode
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 2;
    localparam int RES_W  = ACC_W - 8;
    localparam logic [RES_W-1:0] PIX_MAX = RES_W'((1 << DATA_W) - 1);
    localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(128);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_SEPIA  = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;
    localparam logic [1:0] MODE_CUSTOM = 2'd3;

    localparam logic [7:0] SEPIA_C [9] = '{8'd101, 8'd197, 8'd48,
                                           8'd89,  8'd176, 8'd43,
                                           8'd70,  8'd137, 8'd34};
    localparam logic [7:0] GRAY_C  [3] = '{8'd77, 8'd150, 8'd29};

    // Frame state and coefficient banks
    logic [1:0]          frame_mode_q, frame_mode_d;
    logic [COEF_W-1:0]   shadow_q [9];
    logic [COEF_W-1:0]   shadow_d [9];
    logic [COEF_W-1:0]   active_q [9];
    logic [COEF_W-1:0]   active_d [9];

    // S1: products
    logic                s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
    logic                s1_byp_q, s1_byp_d;
    logic [3*DATA_W-1:0] s1_rgb_q, s1_rgb_d;
    logic [PROD_W-1:0]   s1_prod_q [9];
    logic [PROD_W-1:0]   s1_prod_d [9];

    // S2: row sums
    logic                s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_eol_q, s2_eol_d;
    logic                s2_byp_q, s2_byp_d;
    logic [3*DATA_W-1:0] s2_rgb_q, s2_rgb_d;
    logic [ACC_W-1:0]    s2_sum_q [3];
    logic [ACC_W-1:0]    s2_sum_d [3];

    // S3: output register
    logic                out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic [3*DATA_W-1:0] out_rgb_q, out_rgb_d;

    logic                en;
    logic                accept;
    logic [1:0]          mode_now;
    logic [COEF_W-1:0]   coef [9];
    logic [DATA_W-1:0]   x [3];
    logic [RES_W-1:0]    res;

    always_comb begin
        en       = !out_valid_q || px.out_ready;
        accept   = px.in_valid && en;
        // A start-of-frame beat already uses the newly requested mode and the
        // shadow bank it is about to latch, so the first pixel is consistent.
        mode_now = px.in_sof ? sel : frame_mode_q;

        for (int c = 0; c < 3; c++) begin
            x[c] = px.in_rgb[(2-c)*DATA_W +: DATA_W];
        end

        for (int k = 0; k < 9; k++) begin
            coef[k] = '0;
            case (mode_now)
                MODE_SEPIA:  coef[k] = COEF_W'(SEPIA_C[k]);
                MODE_GRAY:   coef[k] = COEF_W'(GRAY_C[k % 3]);
                MODE_CUSTOM: coef[k] = px.in_sof ? shadow_q[k] : active_q[k];
                default:     coef[k] = '0;
            endcase
        end

        frame_mode_d = frame_mode_q;
        for (int k = 0; k < 9; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
        end
        if (cfg_we && (cfg_addr < 4'd9)) begin
            shadow_d[cfg_addr] = cfg_data;
        end
        // Copy uses the pre-write shadow, so a coincident cfg write waits a frame.
        if (accept && px.in_sof) begin
            frame_mode_d = sel;
            for (int k = 0; k < 9; k++) begin
                active_d[k] = shadow_q[k];
            end
        end

        s1_valid_d = s1_valid_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        s1_byp_d   = s1_byp_q;
        s1_rgb_d   = s1_rgb_q;
        for (int k = 0; k < 9; k++) begin
            s1_prod_d[k] = s1_prod_q[k];
        end
        s2_valid_d = s2_valid_q;
        s2_sof_d   = s2_sof_q;
        s2_eol_d   = s2_eol_q;
        s2_byp_d   = s2_byp_q;
        s2_rgb_d   = s2_rgb_q;
        for (int r = 0; r < 3; r++) begin
            s2_sum_d[r] = s2_sum_q[r];
        end
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        out_rgb_d   = out_rgb_q;
        res         = '0;

        if (en) begin
            s1_valid_d = px.in_valid;
            s1_sof_d   = px.in_sof;
            s1_eol_d   = px.in_eol;
            s1_byp_d   = (mode_now == MODE_BYPASS);
            s1_rgb_d   = px.in_rgb;
            for (int k = 0; k < 9; k++) begin
                s1_prod_d[k] = PROD_W'(coef[k]) * PROD_W'(x[k % 3]);
            end

            s2_valid_d = s1_valid_q;
            s2_sof_d   = s1_sof_q;
            s2_eol_d   = s1_eol_q;
            s2_byp_d   = s1_byp_q;
            s2_rgb_d   = s1_rgb_q;
            for (int r = 0; r < 3; r++) begin
                s2_sum_d[r] = ACC_W'(s1_prod_q[3*r]) + ACC_W'(s1_prod_q[3*r+1])
                            + ACC_W'(s1_prod_q[3*r+2]) + ROUND_HALF;
            end

            out_valid_d = s2_valid_q;
            out_sof_d   = s2_sof_q;
            out_eol_d   = s2_eol_q;
            for (int r = 0; r < 3; r++) begin
                res = s2_sum_q[r][ACC_W-1:8];
                out_rgb_d[(2-r)*DATA_W +: DATA_W] = (res > PIX_MAX) ? {DATA_W{1'b1}}
                                                                     : res[DATA_W-1:0];
            end
            if (s2_byp_q) begin
                out_rgb_d = s2_rgb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_mode_q <= MODE_BYPASS;
            for (int k = 0; k < 9; k++) begin
                // Identity matrix: diagonal entries 0, 4, 8 hold 1.0 in Q.8
                shadow_q[k]  <= (k % 4 == 0) ? COEF_W'(256) : '0;
                active_q[k]  <= (k % 4 == 0) ? COEF_W'(256) : '0;
                s1_prod_q[k] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_rgb_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            s2_byp_q   <= 1'b0;
            s2_rgb_q   <= '0;
            for (int r = 0; r < 3; r++) begin
                s2_sum_q[r] <= '0;
            end
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            frame_mode_q <= frame_mode_d;
            for (int k = 0; k < 9; k++) begin
                shadow_q[k]  <= shadow_d[k];
                active_q[k]  <= active_d[k];
                s1_prod_q[k] <= s1_prod_d[k];
            end
            s1_valid_q <= s1_valid_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s1_byp_q   <= s1_byp_d;
            s1_rgb_q   <= s1_rgb_d;
            s2_valid_q <= s2_valid_d;
            s2_sof_q   <= s2_sof_d;
            s2_eol_q   <= s2_eol_d;
            s2_byp_q   <= s2_byp_d;
            s2_rgb_q   <= s2_rgb_d;
            for (int r = 0; r < 3; r++) begin
                s2_sum_q[r] <= s2_sum_d[r];
            end
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign px.in_ready  = en;
    assign px.out_valid = out_valid_q;
    assign px.out_sof   = out_sof_q;
    assign px.out_eol   = out_eol_q;
    assign px.out_rgb   = out_rgb_q;
    assign frame_mode   = frame_mode_q;
endmodule

// File: tb/tb_color_matrix_stream.sv
// tb/tb_color_matrix_stream.sv - directed self-checking bench for color_matrix_stream
module tb_color_matrix_stream;
    localparam int DATA_W = 8;
    localparam int COEF_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        sel = 2'd0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = 4'd0;
    logic [COEF_W-1:0] cfg_data = '0;
    logic [1:0]        frame_mode;

    int checks = 0;
    int errors = 0;

    color_matrix_stream_if #(.DATA_W(DATA_W)) px ();

    color_matrix_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .px         (px),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .frame_mode (frame_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rgb(input int r, input int g, input int b);
        rgb = {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic int clamp(input int v);
        clamp = (v > 255) ? 255 : v;
    endfunction

    function automatic logic [23:0] sepia_ref(input logic [23:0] v);
        int r, g, b;
        r = int'(v[23:16]);
        g = int'(v[15:8]);
        b = int'(v[7:0]);
        sepia_ref = rgb(clamp((101*r + 197*g + 48*b + 128) / 256),
                        clamp((89*r + 176*g + 43*b + 128) / 256),
                        clamp((70*r + 137*g + 34*b + 128) / 256));
    endfunction

    function automatic logic [23:0] bp_vec(input int i);
        bp_vec = rgb(i*16 + 3, 255 - i*13, i*7 + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [COEF_W-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Single beat through an empty pipe; result expected after the third edge.
    task automatic pix(input logic [1:0] s, input logic [23:0] v, input logic sof,
                       input logic eol, input logic [23:0] exp, input string tag);
        sel = s;
        px.out_ready = 1'b1;
        px.in_valid = 1'b1;
        px.in_rgb = v;
        px.in_sof = sof;
        px.in_eol = eol;
        check({tag, "_in_ready"}, px.in_ready, 1);
        step();
        px.in_valid = 1'b0;
        px.in_sof = 1'b0;
        px.in_eol = 1'b0;
        check({tag, "_lat1"}, px.out_valid, 0);
        step();
        check({tag, "_lat2"}, px.out_valid, 0);
        step();
        check({tag, "_valid"}, px.out_valid, 1);
        check({tag, "_rgb"}, px.out_rgb, exp);
        check({tag, "_sof"}, px.out_sof, sof);
        check({tag, "_eol"}, px.out_eol, eol);
        step();
    endtask

    initial begin
        px.in_valid = 1'b0;
        px.in_sof = 1'b0;
        px.in_eol = 1'b0;
        px.in_rgb = '0;
        px.out_ready = 1'b1;

        #2;
        check("rst_out_valid", px.out_valid, 0);
        check("rst_out_rgb", px.out_rgb, 0);
        check("rst_frame_mode", frame_mode, 0);
        check("rst_in_ready", px.in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Sepia
        pix(2'd1, rgb(100, 50, 20), 1'b1, 1'b0, rgb(82, 73, 57), "sepia");
        check("sepia_mode", frame_mode, 1);
        pix(2'd1, rgb(255, 255, 255), 1'b0, 1'b1, rgb(255, 255, 240), "sepia_sat");

        // Grayscale, then mid-frame sel change has no effect
        pix(2'd2, rgb(100, 50, 20), 1'b1, 1'b0, rgb(62, 62, 62), "gray");
        check("gray_mode", frame_mode, 2);
        pix(2'd1, rgb(100, 50, 20), 1'b0, 1'b0, rgb(62, 62, 62), "gray_hold");
        check("gray_mode_hold", frame_mode, 2);
        pix(2'd1, rgb(100, 50, 20), 1'b1, 1'b0, rgb(82, 73, 57), "sepia_next");
        check("sepia_next_mode", frame_mode, 1);

        // Custom coefficients
        cfg_write(4'd0, 10'd512);
        cfg_write(4'd4, 10'd0);
        cfg_write(4'd8, 10'd0);
        cfg_write(4'd9, 10'd1023);
        pix(2'd3, rgb(100, 7, 9), 1'b1, 1'b0, rgb(200, 0, 0), "cust");
        check("cust_mode", frame_mode, 3);
        pix(2'd3, rgb(200, 7, 9), 1'b0, 1'b0, rgb(255, 0, 0), "cust_sat");
        cfg_write(4'd0, 10'd256);
        pix(2'd3, rgb(100, 7, 9), 1'b0, 1'b0, rgb(200, 0, 0), "cust_midwr");
        pix(2'd3, rgb(100, 7, 9), 1'b1, 1'b0, rgb(100, 0, 0), "cust_newfrm");
        cfg_we = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 10'd768;
        pix(2'd3, rgb(50, 7, 9), 1'b1, 1'b0, rgb(50, 0, 0), "cust_coinc");
        cfg_we = 1'b0;
        pix(2'd3, rgb(50, 7, 9), 1'b1, 1'b0, rgb(150, 0, 0), "cust_coinc_next");

        // Back-pressure: 16 sepia pixels with random out_ready
        sel = 2'd1;
        fork
            begin : producer
                logic acc;
                int   guard;
                for (int i = 0; i < 16; i++) begin
                    px.in_valid = 1'b1;
                    px.in_rgb = bp_vec(i);
                    px.in_sof = (i == 0);
                    px.in_eol = (i % 4 == 3);
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = px.in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!acc && guard < 200);
                end
                px.in_valid = 1'b0;
                px.in_sof = 1'b0;
                px.in_eol = 1'b0;
            end
            begin : consumer
                int          got;
                int          cyc;
                logic        prev_stall;
                logic [23:0] prev_rgb;
                got = 0;
                cyc = 0;
                prev_stall = 1'b0;
                prev_rgb = '0;
                while (got < 16 && cyc < 1000) begin
                    @(posedge clk);
                    #1;
                    px.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) begin
                        check("bp_hold_valid", px.out_valid, 1);
                        check("bp_hold_rgb", px.out_rgb, prev_rgb);
                    end
                    if (px.out_valid && px.out_ready) begin
                        check("bp_rgb", px.out_rgb, sepia_ref(bp_vec(got)));
                        check("bp_sof", px.out_sof, (got == 0));
                        check("bp_eol", px.out_eol, (got % 4 == 3));
                        got++;
                    end
                    prev_stall = px.out_valid && !px.out_ready;
                    prev_rgb = px.out_rgb;
                end
                check("bp_count", got, 16);
            end
        join
        px.out_ready = 1'b1;
        step();
        step();
        step();
        check("bp_drained", px.out_valid, 0);

        // Reset with three beats in flight
        sel = 2'd1;
        px.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            px.in_rgb = rgb(10 + i, 20, 30);
            px.in_sof = (i == 0);
            step();
        end
        px.in_valid = 1'b0;
        px.in_sof = 1'b0;
        check("pre_rst_valid", px.out_valid, 1);
        check("pre_rst_mode", frame_mode, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", px.out_valid, 0);
        check("mid_rst_out_rgb", px.out_rgb, 0);
        check("mid_rst_mode", frame_mode, 0);
        check("mid_rst_in_ready", px.in_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_stale", px.out_valid, 0);
        end
        pix(2'd1, rgb(12, 34, 56), 1'b0, 1'b0, rgb(12, 34, 56), "post_rst_bypass");
        check("post_rst_mode", frame_mode, 0);
        pix(2'd3, rgb(12, 34, 56), 1'b1, 1'b0, rgb(12, 34, 56), "post_rst_identity");
        check("post_rst_cust_mode", frame_mode, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
